rob_core: RTL

- Parametrised single-clock reorder buffer, successor to the current dual-clock ROB stage.
- Decode allocates entries in order. Execute writes results back out of order by tag. Writeback retires entries in order from the head.
- New over the previous generation:
  - configurable depth, data width and number of source-lookup ports;
  - same-cycle writeback bypass on lookups;
  - mispredict flush of all younger entries at commit;
  - occupancy count output.

---
 rtl/rob_core.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rob_core.sv
// rob_core: single-clock reorder buffer.
// Decode allocates entries in order at the tail. Execute completes entries
// out of order by tag. Writeback retires DONE entries in order from the head.
// Operand lookups see same-cycle writeback data through a bypass path.
// A mispredicted entry reaching commit frees every younger entry.
module rob_core #(
    parameter int ADDR   = 5,
    parameter int DATA_W = 32,
    parameter int NSRC   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   alloc_valid,
    input  logic [4:0]             alloc_rd,
    input  logic                   alloc_regWrite,
    input  logic                   alloc_memWrite,
    output logic                   alloc_ready,
    output logic [ADDR-1:0]        alloc_tag,
    input  logic                   wb_valid,
    input  logic [ADDR-1:0]        wb_tag,
    input  logic [DATA_W-1:0]      wb_result,
    input  logic [DATA_W-1:0]      wb_memData,
    input  logic                   wb_mispredict,
    output logic                   commit_valid,
    input  logic                   commit_ready,
    output logic [4:0]             commit_rd,
    output logic                   commit_regWrite,
    output logic                   commit_memWrite,
    output logic [DATA_W-1:0]      commit_result,
    output logic [DATA_W-1:0]      commit_memData,
    output logic [ADDR-1:0]        commit_tag,
    output logic                   flush,
    input  logic [NSRC*ADDR-1:0]   src_tag,
    output logic [NSRC-1:0]        src_valid,
    output logic [NSRC*DATA_W-1:0] src_data,
    output logic [ADDR:0]          count,
    output logic                   full,
    output logic                   empty
);

    localparam int DEPTH = 1 << ADDR;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_ISSUED = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [ADDR:0] PTR_ONE  = {{ADDR{1'b0}}, 1'b1};
    localparam logic [ADDR:0] CNT_ZERO = {(ADDR+1){1'b0}};
    localparam logic [ADDR:0] CNT_FULL = {1'b1, {ADDR{1'b0}}};

    // Per-slot storage
    logic [1:0]        r_state    [DEPTH];
    logic              r_mispred  [DEPTH];
    logic [4:0]        r_rd       [DEPTH];
    logic              r_regwrite [DEPTH];
    logic              r_memwrite [DEPTH];
    logic [DATA_W-1:0] r_result   [DEPTH];
    logic [DATA_W-1:0] r_memdata  [DEPTH];

    // Pointers carry one extra MSB so full and empty are distinguishable
    logic [ADDR:0]     r_head;
    logic [ADDR:0]     r_tail;

    logic [ADDR-1:0]   w_head_idx;
    logic [ADDR-1:0]   w_tail_idx;
    logic [ADDR:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_alloc;
    logic              w_wb;
    logic              w_commit_valid;
    logic              w_commit;
    logic              w_flush;

    assign w_head_idx     = r_head[ADDR-1:0];
    assign w_tail_idx     = r_tail[ADDR-1:0];
    assign w_count        = r_tail - r_head;
    assign w_full         = (w_count == CNT_FULL);
    assign w_empty        = (w_count == CNT_ZERO);
    // Full is judged on the pre-edge count; a same-cycle commit does not help
    assign w_alloc        = alloc_valid & ~w_full;
    // Writebacks only land on slots still waiting for a result
    assign w_wb           = wb_valid & (r_state[wb_tag] == ST_ISSUED);
    assign w_commit_valid = (r_state[w_head_idx] == ST_DONE) & ~w_empty;
    assign w_commit       = w_commit_valid & commit_ready;
    assign w_flush        = w_commit & r_mispred[w_head_idx];

    assign alloc_ready     = ~w_full;
    assign alloc_tag       = w_tail_idx;
    assign commit_valid    = w_commit_valid;
    assign commit_rd       = r_rd[w_head_idx];
    assign commit_regWrite = r_regwrite[w_head_idx];
    assign commit_memWrite = r_memwrite[w_head_idx];
    assign commit_result   = r_result[w_head_idx];
    assign commit_memData  = r_memdata[w_head_idx];
    assign commit_tag      = w_head_idx;
    assign flush           = w_flush;
    assign count           = w_count;
    assign full            = w_full;
    assign empty           = w_empty;

    // Operand lookup: same-cycle writeback bypass first, then stored result
    always_comb begin
        src_valid = {NSRC{1'b0}};
        src_data  = {(NSRC*DATA_W){1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            if (wb_valid && (wb_tag == src_tag[i*ADDR +: ADDR]) &&
                (r_state[src_tag[i*ADDR +: ADDR]] == ST_ISSUED)) begin
                src_valid[i]                = 1'b1;
                src_data[i*DATA_W +: DATA_W] = wb_result;
            end else if ((r_state[src_tag[i*ADDR +: ADDR]] == ST_DONE) &&
                         r_regwrite[src_tag[i*ADDR +: ADDR]]) begin
                src_valid[i]                = 1'b1;
                src_data[i*DATA_W +: DATA_W] = r_result[src_tag[i*ADDR +: ADDR]];
            end else begin
                src_valid[i]                = 1'b0;
                src_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
        end
    end

    // Slot state, payload and pointer update; flush overrides alloc and writeback
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head <= CNT_ZERO;
            r_tail <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i]    <= ST_FREE;
                r_mispred[i]  <= 1'b0;
                r_rd[i]       <= 5'd0;
                r_regwrite[i] <= 1'b0;
                r_memwrite[i] <= 1'b0;
                r_result[i]   <= {DATA_W{1'b0}};
                r_memdata[i]  <= {DATA_W{1'b0}};
            end
        end else if (w_flush) begin
            // Everything younger than the mispredicted entry is discarded
            r_head <= r_head + PTR_ONE;
            r_tail <= r_head + PTR_ONE;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i]   <= ST_FREE;
                r_mispred[i] <= 1'b0;
            end
        end else begin
            if (w_alloc) begin
                r_state[w_tail_idx]    <= ST_ISSUED;
                r_mispred[w_tail_idx]  <= 1'b0;
                r_rd[w_tail_idx]       <= alloc_rd;
                r_regwrite[w_tail_idx] <= alloc_regWrite;
                r_memwrite[w_tail_idx] <= alloc_memWrite;
                r_result[w_tail_idx]   <= {DATA_W{1'b0}};
                r_memdata[w_tail_idx]  <= {DATA_W{1'b0}};
                r_tail                 <= r_tail + PTR_ONE;
            end
            if (w_wb) begin
                r_state[wb_tag]   <= ST_DONE;
                r_result[wb_tag]  <= wb_result;
                r_memdata[wb_tag] <= wb_memData;
                r_mispred[wb_tag] <= wb_mispredict;
            end
            if (w_commit) begin
                r_state[w_head_idx] <= ST_FREE;
                r_head              <= r_head + PTR_ONE;
            end
        end
    end

endmodule
